elevator_req_latch: RTL

//  Upstream request stage for the elevator controller. Synchronises and debounces raw

---
 rtl/elevator_req_latch.sv | 109 ++++++++++
 1 files changed

// File: rtl/elevator_req_latch.sv
// Floor-call request stage: synchronise, debounce and latch button presses into
// sticky request bits that the elevator controller clears as it serves each floor.

module elevator_req_bit #(
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    input  logic clr_i,
    output logic des_o
);
    logic            s1_q, s2_q;
    logic            db_q, db_d;
    logic            db_dly_q;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            des_q, des_d;
    logic            press;

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    // A level change is accepted only after it has persisted DB_CYCLES cycles.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press = db_q & ~db_dly_q;

    // clr dominates: a press arriving while clr is high is consumed, not deferred.
    always_comb begin
        des_d = des_q;
        if (clr_i) begin
            des_d = 1'b0;
        end else if (press) begin
            des_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= '0;
            des_q    <= 1'b0;
        end else begin
            s1_q     <= btn_i;
            s2_q     <= s1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
            des_q    <= des_d;
        end
    end

    assign des_o = des_q;
endmodule

module elevator_req_latch #(
    parameter int N_FLOORS  = 4,
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 3,
    localparam int CNT_W    = $clog2(N_FLOORS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_FLOORS-1:0] btn_i,
    input  logic [N_FLOORS-1:0] clr_i,
    output logic [N_FLOORS-1:0] des_o,
    output logic                any_req_o,
    output logic [CNT_W-1:0]    pend_cnt_o
);
    logic [N_FLOORS-1:0] des;
    logic [CNT_W-1:0]    pend_cnt;

    for (genvar i = 0; i < N_FLOORS; i++) begin : g_floor
        elevator_req_bit #(
            .DB_CYCLES(DB_CYCLES),
            .DB_W     (DB_W)
        ) u_bit (
            .clk_i(clk_i),
            .rst_i(rst_i),
            .btn_i(btn_i[i]),
            .clr_i(clr_i[i]),
            .des_o(des[i])
        );
    end

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            pend_cnt = pend_cnt + CNT_W'(des[i]);
        end
    end

    assign des_o      = des;
    assign any_req_o  = |des;
    assign pend_cnt_o = pend_cnt;
endmodule
